// File: rtl/uart_rx_ack.sv
// 8N1 UART receiver: synchronised RX pin, 3-sample mid-bit majority vote,
// received byte held with rx_ready until rx_ack; framing/overrun pulses.
module uart_rx_ack #(
  parameter int unsigned CLKS_PER_BIT = 1085,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] SAMP_LO  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] SAMP_MID = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] SAMP_HI  = CNT_W'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs, rxs_d, fall;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [2:0]             bit_idx, bit_idx_nxt;
  logic [1:0]             samp, samp_nxt;
  logic                   maj;
  logic [7:0]             shift, shift_nxt, rx_data_nxt;
  logic                   rx_ready_nxt, frame_err_nxt, overrun_nxt;

  // Input synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      rxs_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
      rxs_d  <= rxs;
    end
  end

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign fall = rxs_d & ~rxs;
  // Third sample is the live rxs at SAMP_HI, so the vote resolves in that cycle.
  assign maj  = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      samp      <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      samp      <= samp_nxt;
      shift     <= shift_nxt;
      rx_data   <= rx_data_nxt;
      rx_ready  <= rx_ready_nxt;
      frame_err <= frame_err_nxt;
      overrun   <= overrun_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + 1'b1;
    bit_idx_nxt   = bit_idx;
    samp_nxt      = samp;
    shift_nxt     = shift;
    rx_data_nxt   = rx_data;
    rx_ready_nxt  = rx_ready;
    frame_err_nxt = 1'b0;
    overrun_nxt   = 1'b0;

    if (rx_ack) begin
      rx_ready_nxt = 1'b0;
    end

    if (cnt == SAMP_LO) begin
      samp_nxt[0] = rxs;
    end
    if (cnt == SAMP_MID) begin
      samp_nxt[1] = rxs;
    end

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (fall) begin
          state_nxt = START;
        end
      end
      START: begin
        if (cnt == SAMP_HI && maj) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = DATA;
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (cnt == SAMP_HI) begin
          shift_nxt = {maj, shift[7:1]};
        end
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        // Decide at mid stop bit and rearm at once so back-to-back frames are caught.
        if (cnt == SAMP_HI) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (!maj) begin
            frame_err_nxt = 1'b1;
          end else if (rx_ready) begin
            overrun_nxt = 1'b1;
          end else begin
            rx_data_nxt  = shift;
            rx_ready_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ack.sv
// Self-checking bench for uart_rx_ack: directed table, corner sequences and
// randomized frames checked against an event-level receiver model.
module tb_uart_rx_ack;

  localparam int unsigned CPB = 16;
  localparam int EV_NONE = 0;
  localparam int EV_DEL  = 1;
  localparam int EV_FE   = 2;
  localparam int EV_OV   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_ack #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .rx_data(rx_data),
    .rx_ready(rx_ready), .rx_ack(rx_ack), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic [7:0] d;
    bit         stop_ok;
    int         spike;
    int         pre_ack;
    int         post_ack;
    int         kind;
    logic [7:0] exp_d;
    logic       exp_rdy;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic got_event(input int kind, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", kind, EV_NONE);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == EV_DEL || kind == EV_OV) check("event_data", d, e.data);
    end
  endtask

  // Output monitor, sampled just after each rising edge.
  logic       mon_en = 1'b0;
  logic       rdy_p = 1'b0;
  logic       fe_p = 1'b0;
  logic       ov_p = 1'b0;
  logic [7:0] data_p = 8'h00;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (rx_ready && !rdy_p) got_event(EV_DEL, rx_data);
        if (frame_err) got_event(EV_FE, rx_data);
        if (overrun) got_event(EV_OV, rx_data);
        if (frame_err || overrun) begin
          check("fe_ov_exclusive", frame_err && overrun, 0);
          check("pulse_width", (frame_err && fe_p) || (overrun && ov_p), 0);
        end
        if (rdy_p && rx_ready) check("data_stable", rx_data, data_p);
        if (rdy_p && rx_ack) check("ack_clears", rx_ready, 0);
      end
      rdy_p  = rx_ready;
      fe_p   = frame_err;
      ov_p   = overrun;
      data_p = rx_data;
    end
  end

  // Acknowledge driver: manual holds requested by the test, or automatic ack
  // a fixed delay after each rx_ready rise.
  int   man_seq = 0;
  int   man_len = 0;
  int   auto_dly = 0;
  int   ack_seen = 0;
  int   ack_left = 0;
  int   ack_wait = 0;
  logic ack_rp = 1'b0;
  initial begin
    rx_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (man_seq != ack_seen) begin
        ack_seen = man_seq;
        ack_left = man_len;
      end
      if (auto_dly > 0 && rx_ready && !ack_rp) begin
        ack_wait = auto_dly;
      end else if (ack_wait > 0) begin
        ack_wait--;
        if (ack_wait == 0) ack_left = 1;
      end
      ack_rp = rx_ready;
      rx_ack = (ack_left > 0);
      if (ack_left > 0) ack_left--;
    end
  end

  task automatic do_ack(input int len);
    man_len = len;
    man_seq++;
    repeat (len + 3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int spike,
                            input bit chk_lat, input int gap);
    logic [9:0] bits;
    bits = {stop_ok, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int o = 0; o < int'(CPB); o++) begin
        @(negedge clk);
        uart_rxd = bits[b];
        if (spike >= 0 && b == spike + 1 && o == 9) uart_rxd = 1'b0;
        if (chk_lat && b == 9 && o == 12) begin
          check("lat_rdy_before", rx_ready, 0);
          check("busy_in_stop", busy, 1);
        end
        if (chk_lat && b == 9 && o == 13) begin
          check("lat_rdy_after", rx_ready, 1);
          check("lat_data", rx_data, d);
          check("busy_after_stop", busy, 0);
        end
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      uart_rxd = 1'b1;
    end
  endtask

  logic [7:0] held;
  logic       pending;
  logic [7:0] rd;
  bit         rstop;
  int         rspike;
  int         rgap;

  initial begin
    tbl[0] = '{8'h41, 1'b1, -1, 0, 1, EV_DEL, 8'h41, 1'b1};
    tbl[1] = '{8'h0D, 1'b1, -1, 5, 1, EV_DEL, 8'h0D, 1'b1};
    tbl[2] = '{8'h55, 1'b0, -1, 0, 0, EV_FE,  8'h00, 1'b0};
    tbl[3] = '{8'hA3, 1'b1, -1, 0, 1, EV_DEL, 8'hA3, 1'b1};
    tbl[4] = '{8'h31, 1'b1, -1, 0, 0, EV_DEL, 8'h31, 1'b1};
    tbl[5] = '{8'h32, 1'b1, -1, 0, 1, EV_OV,  8'h31, 1'b1};
    tbl[6] = '{8'h33, 1'b1, -1, 0, 1, EV_DEL, 8'h33, 1'b1};
    tbl[7] = '{8'h5A, 1'b1,  3, 0, 1, EV_DEL, 8'h5A, 1'b1};

    rst = 1'b1;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_ready", rx_ready, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    mon_en = 1'b1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].pre_ack > 0) do_ack(tbl[i].pre_ack);
      if (tbl[i].kind != EV_NONE) push_ev(tbl[i].kind, tbl[i].exp_d);
      send_frame(tbl[i].d, tbl[i].stop_ok, tbl[i].spike, (i == 0), 4);
      repeat (10) @(negedge clk);
      check("vec_rdy", rx_ready, tbl[i].exp_rdy);
      if (tbl[i].exp_rdy) check("vec_data", rx_data, tbl[i].exp_d);
      if (tbl[i].post_ack > 0) do_ack(tbl[i].post_ack);
    end

    // Short low glitch on an idle line.
    repeat (4) begin
      @(negedge clk);
      uart_rxd = 1'b0;
    end
    @(negedge clk);
    uart_rxd = 1'b1;
    @(negedge clk);
    check("glitch_busy", busy, 1);
    repeat (30) @(negedge clk);
    check("glitch_idle", busy, 0);
    check("glitch_no_rdy", rx_ready, 0);

    // "abc" back-to-back with an automatic ack two cycles after each rx_ready.
    auto_dly = 2;
    push_ev(EV_DEL, 8'h61);
    send_frame(8'h61, 1'b1, -1, 1'b0, 0);
    push_ev(EV_DEL, 8'h62);
    send_frame(8'h62, 1'b1, -1, 1'b0, 0);
    push_ev(EV_DEL, 8'h63);
    send_frame(8'h63, 1'b1, -1, 1'b0, 10);
    check("abc_acked", rx_ready, 0);
    check("abc_last", rx_data, 8'h63);
    auto_dly = 0;

    // Reset in the middle of a fourth frame.
    for (int b = 0; b < 4; b++) begin
      for (int o = 0; o < int'(CPB); o++) begin
        @(negedge clk);
        uart_rxd = (b == 0) ? 1'b0 : 1'b0;
      end
    end
    check("midframe_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    uart_rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", frame_err | overrun, 0);
    repeat (200) @(negedge clk);
    check("rst_no_partial", rx_ready, 0);

    // Randomized frames against the event-level model.
    pending = 1'b0;
    held = 8'h00;
    for (int i = 0; i < 20; i++) begin
      rd = 8'($urandom);
      rstop = ($urandom_range(0, 5) != 0);
      rspike = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      rgap = rstop ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
      if (!rstop) begin
        push_ev(EV_FE, 8'h00);
      end else if (pending) begin
        push_ev(EV_OV, held);
      end else begin
        push_ev(EV_DEL, rd);
        pending = 1'b1;
        held = rd;
      end
      send_frame(rd, rstop, rspike, 1'b0, rgap);
      check("rand_rdy", rx_ready, pending);
      if (pending) check("rand_data", rx_data, held);
      if ($urandom_range(0, 3) != 0) begin
        do_ack(int'($urandom_range(1, 4)));
        pending = 1'b0;
      end
    end

    repeat (20) @(negedge clk);
    check("events_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ack.md
Name: uart_rx_ack

Overview:
- Serial UART receiver (8N1) that sits directly upstream of the UART-to-SHA3 bridge and feeds its rx_data / rx_ready / rx_ack byte handshake.
- Synchronises the asynchronous RX pin and samples each bit at mid-bit with a 3-sample majority vote.
- Holds each received byte stable with rx_ready high until the bridge acknowledges it.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 1085: clk cycles per UART bit (125 MHz / 115200). Legal range is 8 to 65535.
- SYNC_STAGES, 2: number of flip-flops in the RX input synchroniser. Must be 2 or more.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- uart_rxd  in  1  asynchronous serial input; idles high.
- rx_data  out  8  received byte; stable while rx_ready=1.
- rx_ready  out  1  byte available; held high until acknowledged.
- rx_ack  in  1  consumer acknowledge; may be held high for several cycles.
- frame_err  out  1  one-cycle pulse when a stop bit samples 0.
- overrun  out  1  one-cycle pulse when a byte completes while rx_ready=1.
- busy  out  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; all counters clear.
  - rx_data=0, rx_ready=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flip-flops are set to 1.
  - Reset mid-frame abandons the partial byte with no pulse.
- Synchronisation:
  - uart_rxd passes through SYNC_STAGES flip-flops; only the synchronised value (rxs) is used.
  - The falling-edge detect compares rxs with its previous registered value.
- Bit counter:
  - cnt counts 0 to CLKS_PER_BIT-1 within each bit.
  - Samples are taken at cnt = H-1, H and H+1, where H = CLKS_PER_BIT/2 (integer division).
  - The bit value is the majority of the three samples.
- State machine:
  - IDLE: on a falling edge of rxs, clear cnt and go to START.
  - START: at cnt=H+1, evaluate the majority.
    - Majority 1 (glitch): return to IDLE with no pulse.
    - Majority 0: continue; at cnt=CLKS_PER_BIT-1, clear cnt and go to DATA with bit index 0.
  - DATA: at cnt=H+1, shift the majority into shift[7], shifting right, so the data is LSB first.
    - At cnt=CLKS_PER_BIT-1: if bit index is 7, go to STOP; otherwise increment the index.
  - STOP: at cnt=H+1, decide the byte and return to IDLE in the same cycle (no full-bit wait), so back-to-back frames are caught.
    - Majority 0: pulse frame_err; rx_data and rx_ready are unchanged.
    - Majority 1 and rx_ready=0: on the next edge rx_data<=shift and rx_ready<=1.
    - Majority 1 and rx_ready=1: pulse overrun; the new byte is dropped; rx_data and rx_ready are unchanged.
- Latency: rx_ready rises one clk after the STOP decision cycle.
- Handshake:
  - When rx_ack=1 is sampled with rx_ready=1, rx_ready clears on that edge, so it is low the next cycle.
  - rx_ack while rx_ready=0 is ignored, including an ack held high from a previous byte.
  - A byte delivery and an ack in the same cycle cannot coincide, because delivery requires rx_ready=0.
  - An ack that clears rx_ready in the same cycle as a STOP decision counts as rx_ready=1 for that decision: the new byte overruns (old value wins).
- frame_err and overrun are never high at the same time; each is exactly 1 cycle wide.
- The RX path never stalls; the receiver keeps sampling regardless of rx_ready.

Test Plan (CLKS_PER_BIT=16):
- Reset, drive 8N1 byte 0x41 ('A'), hold rx_ack=0 -> rx_ready=1 and rx_data=0x41 exactly 1 clk after the stop-bit H+1 sample. rx_data stays stable until ack.
- With rx_ready=1, pulse rx_ack for 1 cycle -> rx_ready=0 next cycle. Then hold rx_ack=1 for 5 cycles -> no effect on the next byte 0x0D, which still asserts rx_ready.
- Send 0x55 with stop bit driven 0 -> frame_err one-cycle pulse, rx_ready remains 0, next valid byte 0xA3 is received correctly.
- Leave byte 0x31 unacked, send 0x32 -> overrun pulse, rx_data stays 0x31. After ack, send 0x33 -> rx_data=0x33.
- Drive a 4-cycle low glitch on idle line -> returns to IDLE, no rx_ready, no frame_err. Also apply a 1-cycle low spike inside a data-bit sample window -> majority vote keeps the correct bit.
- Send "abc" back-to-back (no idle gap) with the ack given 2 cycles after each rx_ready -> 0x61, 0x62, 0x63 in order. Assert rst mid-byte of a 4th frame -> all outputs 0, no rx_ready for the partial frame.
